// File: rtl/div_unit.sv
// div_unit: 32-bit multicycle DIV/DIVU unit, radix-2 restoring, 32 iterations.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] lo,
  output logic [31:0] hi
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, next;
  logic [4:0] cnt;
  logic [31:0] q, rem, dvs, q_nxt, r_nxt;
  logic [32:0] shifted, diff;
  logic sgn, sa, sb, accept, last;
  always_comb begin
    shifted = {rem, q[31]};
    diff = shifted - {1'b0, dvs};
    q_nxt = {q[30:0], ~diff[32]};
    r_nxt = diff[32] ? shifted[31:0] : diff[31:0];
    accept = state == IDLE && start && !flush;
    last = state == CALC && cnt == 5'd31;
    next = flush ? IDLE :
           state == IDLE ? (start ? (b == 32'd0 ? DONE : CALC) : IDLE) :
           state == CALC ? (last ? DONE : CALC) : IDLE;
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  // The final step's result is written on the edge entering DONE, so lo/hi are valid while done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      q <= '0;
      rem <= '0;
      dvs <= '0;
      sgn <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
      lo <= '0;
      hi <= '0;
    end else begin
      state <= next;
      if (accept) begin
        sgn <= is_signed;
        sa <= a[31];
        sb <= b[31];
        q <= (is_signed && a[31]) ? -a : a;
        dvs <= (is_signed && b[31]) ? -b : b;
        rem <= '0;
        cnt <= '0;
        if (b == 32'd0) begin
          lo <= '1;
          hi <= a;
        end
      end else if (state == CALC && !flush) begin
        q <= q_nxt;
        rem <= r_nxt;
        cnt <= cnt + 5'd1;
        if (last) begin
          lo <= (sgn && (sa ^ sb)) ? -q_nxt : q_nxt;
          hi <= (sgn && sa) ? -r_nxt : r_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit.
module tb_div_unit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, is_signed = 1'b0, flush = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic busy, done;
  logic [31:0] lo, hi;
  int total = 0, bad = 0;

  div_unit dut (.clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .a(a), .b(b),
                .flush(flush), .busy(busy), .done(done), .lo(lo), .hi(hi));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input logic sg, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] elo, input logic [31:0] ehi, input int lat);
    int n;
    logic busy_ok;
    @(negedge clk);
    is_signed = sg; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_busy"}, {31'd0, busy_ok && busy}, 32'd1);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_hi"}, hi, ehi);
    @(posedge clk); #1;
    chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int dones;
    #1;
    chk("rst_out", {busy, done, 30'd0}, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_hi", hi, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_start", {30'd0, busy, done}, 32'd0);

    run("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 32);
    run("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32);
    run("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32);
    run("divu_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32);
    run("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 32);
    run("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 0);
    run("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 0);

    // Flush on the 10th CALC cycle with a simultaneous start; lo/hi stay from div_m5_0.
    @(negedge clk);
    is_signed = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("pre_flush_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1; start = 1'b1; a = 32'd50; b = 32'd5;
    @(posedge clk); #1;
    chk("flush_out", {30'd0, busy, done}, 32'd0);
    chk("flush_lo", lo, 32'hFFFF_FFFF);
    chk("flush_hi", hi, 32'hFFFF_FFFB);
    flush = 1'b0; start = 1'b0;
    run("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 32);

    // Start while busy is ignored: lo/hi come from the first operands.
    @(negedge clk);
    is_signed = 1'b0; a = 32'd1000; b = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    a = 32'd1; b = 32'd1;
    dones = 0;
    for (int i = 0; i < 40 && dones == 0; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    start = 1'b0;
    chk("busy_start_seen", dones, 1);
    chk("busy_start_lo", lo, 32'd100);
    chk("busy_start_hi", hi, 32'd0);
    repeat (3) @(negedge clk);

    // Reset on the 20th CALC cycle.
    @(negedge clk);
    a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out", {30'd0, busy, done}, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    @(negedge clk); rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    chk("midrst_no_done", dones, 0);
    run("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have no parameters; the datapath is fixed at 32 bits and serves the MIPS DIV/DIVU instructions, which the single-cycle ALU does not execute.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request a divide; sampled only in IDLE.
REQ-005 is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
REQ-006 a  input  32  dividend; sampled with start.
REQ-007 b  input  32  divisor; sampled with start.
REQ-008 flush  input  1  cancels any in-flight divide (pipeline exception or branch flush).
REQ-009 busy  output  1  high in CALC and DONE.
REQ-010 done  output  1  one-cycle pulse when results are valid.
REQ-011 lo  output  32  quotient.
REQ-012 hi  output  32  remainder.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, CALC and DONE, with IDLE as the reset state.
REQ-014 In IDLE with start=1 and flush=0, the block SHALL capture operand magnitudes, the sign flags and is_signed on that edge, and SHALL go to CALC with iteration count 0.
  - Exception: if b=0, it SHALL go to DONE instead.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-016 CALC SHALL perform one radix-2 restoring shift-subtract step per cycle for exactly 32 cycles, then go to DONE.
REQ-017 In DONE, the block SHALL drive done=1 for exactly one cycle, write the final lo/hi on that edge, and return to IDLE on the next edge.
REQ-018 Latency: if start is accepted at edge N, done SHALL be high in the cycle following edge N+32.
  - For b=0, done SHALL be high in the cycle following edge N.
REQ-019 Unsigned mode SHALL produce lo = a / b and hi = a % b (truncating division).
REQ-020 Signed mode SHALL divide the magnitudes and then apply the signs:
  - the quotient SHALL be negated when sign(a) differs from sign(b);
  - the remainder SHALL take the sign of a;
  - the quotient SHALL truncate toward zero.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0x00000000, with no trap and no overflow output.
REQ-022 Divide by zero (b=0) SHALL give lo=0xFFFFFFFF and hi=a, in either mode.
REQ-023 start asserted while busy=1 SHALL be ignored; no queuing.
REQ-024 flush=1 SHALL force IDLE on the next edge from any state.
  - No done pulse SHALL follow the flush.
  - lo/hi SHALL keep their previous values.
  - flush SHALL take priority over start in the same cycle.
REQ-025 lo/hi SHALL change only on the DONE edge and SHALL hold until the next completed divide.
REQ-026 start and flush asserted together in IDLE SHALL not start a divide.

Reset
REQ-027 Asserting rst SHALL immediately put the block in IDLE with busy=0, done=0, lo=0, hi=0, the iteration count at 0 and all internal operand registers at 0.
REQ-028 Reset asserted mid-CALC SHALL abort the divide; no done pulse SHALL appear after reset is released.

Verification
REQ-029 DIVU a=100, b=7 -> done exactly 33 cycles after start, lo=14, hi=2, busy high throughout.
REQ-030 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
REQ-031 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU with the same operands -> lo=0, hi=0x80000000.
REQ-032 DIVU a=5, b=0 -> done one cycle after start, lo=0xFFFFFFFF, hi=5.
REQ-033 Flush and back-to-back sequence:
  - start 100/7, then flush on the 10th CALC cycle -> busy=0 next cycle, no done, lo/hi unchanged;
  - start again in the same cycle as the flush -> ignored;
  - start 9/3 on the following cycle -> lo=3, hi=0.
REQ-034 rst pulsed on the 20th CALC cycle -> all outputs 0 immediately, no done afterwards; a subsequent start 0xFFFFFFFF/1 (DIVU) -> lo=0xFFFFFFFF, hi=0.
